// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the fetch controller's ROM, redirect and decode-side signals.
// The master modport is the fetch controller's view; slave is the environment's view.
interface imem_fetch_ctrl_if #(
    parameter int N = 64
);
    logic         start;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic [31:0]  instr;
    logic [N-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         fault;
    logic [N-1:0] fault_pc;
    logic [15:0]  fetch_count;

    modport master (
        input  start, imem_q, redirect_valid, redirect_pc, instr_ready,
        output imem_addr, instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
    );

    modport slave (
        output start, imem_q, redirect_valid, redirect_pc, instr_ready,
        input  imem_addr, instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the 64-word ROM and buffers
// fetched words in a 2-entry queue toward decode, with redirect and range faults.
module imem_fetch_ctrl #(
    parameter int           N        = 64,
    parameter int           DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    imem_fetch_ctrl_if.master  bus
);
    localparam logic [1:0] Depth = 2'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [31:0]  qInstr_q [2];
    logic [31:0]  qInstr_d [2];
    logic [N-1:0] qPc_q [2];
    logic [N-1:0] qPc_d [2];
    logic         rdPtr_q, rdPtr_d;
    logic         wrPtr_q, wrPtr_d;
    logic [1:0]   count_q, count_d;
    logic         fault_q, fault_d;
    logic [N-1:0] faultPc_q, faultPc_d;
    logic [15:0]  fetchCount_q, fetchCount_d;

    logic pop;
    logic canEnq;
    logic redirectBad;
    logic pcOutOfRange;

    assign pop          = bus.instr_valid && bus.instr_ready;
    assign canEnq       = (count_q < Depth) || ((count_q == Depth) && pop);
    assign redirectBad  = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc[N-1:8] != '0);
    assign pcOutOfRange = (pc_q[N-1:8] != '0);

    // Both redirects and range faults empty the queue, so the queue is only
    // ever non-empty in RUN and instr_valid follows the count directly.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        qInstr_d     = qInstr_q;
        qPc_d        = qPc_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;
        fault_d      = fault_q;
        faultPc_d    = faultPc_q;
        fetchCount_d = fetchCount_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    count_d = 2'd0;
                    rdPtr_d = 1'b0;
                    wrPtr_d = 1'b0;
                    if (redirectBad) begin
                        state_d   = FAULT;
                        fault_d   = 1'b1;
                        faultPc_d = bus.redirect_pc;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (pcOutOfRange) begin
                    count_d   = 2'd0;
                    rdPtr_d   = 1'b0;
                    wrPtr_d   = 1'b0;
                    state_d   = FAULT;
                    fault_d   = 1'b1;
                    faultPc_d = pc_q;
                end else begin
                    if (pop) begin
                        rdPtr_d = ~rdPtr_q;
                    end
                    if (canEnq) begin
                        qInstr_d[wrPtr_q] = bus.imem_q;
                        qPc_d[wrPtr_q]    = pc_q;
                        wrPtr_d           = ~wrPtr_q;
                        pc_d              = pc_q + N'(4);
                        fetchCount_d      = fetchCount_q + 16'd1;
                    end
                    count_d = count_q + 2'(canEnq) - 2'(pop);
                end
            end
            FAULT: begin
                if (bus.redirect_valid) begin
                    if (redirectBad) begin
                        faultPc_d = bus.redirect_pc;
                    end else begin
                        fault_d = 1'b0;
                        pc_d    = bus.redirect_pc;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            qInstr_q[0]  <= '0;
            qInstr_q[1]  <= '0;
            qPc_q[0]     <= '0;
            qPc_q[1]     <= '0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            count_q      <= 2'd0;
            fault_q      <= 1'b0;
            faultPc_q    <= '0;
            fetchCount_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            qInstr_q     <= qInstr_d;
            qPc_q        <= qPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
            faultPc_q    <= faultPc_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign bus.imem_addr   = pc_q[7:2];
    assign bus.instr       = qInstr_q[rdPtr_q];
    assign bus.instr_pc    = qPc_q[rdPtr_q];
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = faultPc_q;
    assign bus.fetch_count = fetchCount_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed stimulus, a scoreboard of expected decode
// handshakes checked by a negedge monitor, plus direct checks of status outputs.
module tb_imem_fetch_ctrl;
    logic clk;
    logic reset;
    logic [31:0] rom [64];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t expQ [$];
    int   passCount;
    int   totalCount;

    imem_fetch_ctrl_if #(.N(64)) bus ();

    imem_fetch_ctrl #(.N(64), .DEPTH(2), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_q = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy);
        bus.start          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        e.instr = ins;
        e.pc    = pc;
        expQ.push_back(e);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Every accepted handshake must match the oldest expected fetch.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_pc", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_instr", {32'h0, bus.instr}, {32'h0, e.instr});
                checkOutput("sb_pc", bus.instr_pc, e.pc);
            end
        end
    end

    initial begin
        passCount  = 0;
        totalCount = 0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'h1000_0000 + 32'(i);
        end
        rom[0] = 32'hf800_0000;
        rom[1] = 32'hf800_8001;

        // Reset state
        resetDut();
        checkOutput("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
        checkOutput("rst_fault", {63'h0, bus.fault}, 64'h0);
        checkOutput("rst_fetch_count", {48'h0, bus.fetch_count}, 64'h0);
        checkOutput("rst_imem_addr", {58'h0, bus.imem_addr}, 64'h0);
        checkOutput("rst_instr", {32'h0, bus.instr}, 64'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 64'h0);
        checkOutput("rst_fault_pc", bus.fault_pc, 64'h0);

        // Streaming fetch with decode always ready
        pushExp(32'hf800_0000, 64'h0);
        pushExp(32'hf800_8001, 64'h4);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("t1_valid_after_start", {63'h0, bus.instr_valid}, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("t1_valid", {63'h0, bus.instr_valid}, 64'h1);
        checkOutput("t1_instr0", {32'h0, bus.instr}, 64'hf800_0000);
        checkOutput("t1_pc0", bus.instr_pc, 64'h0);
        checkOutput("t1_count1", {48'h0, bus.fetch_count}, 64'h1);
        tick();
        checkOutput("t1_instr1", {32'h0, bus.instr}, 64'hf800_8001);
        checkOutput("t1_pc1", bus.instr_pc, 64'h4);
        checkOutput("t1_count2", {48'h0, bus.fetch_count}, 64'h2);
        tick();
        checkOutput("t1_count3", {48'h0, bus.fetch_count}, 64'h3);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);

        // Backpressure fills the queue, then drains without bubbles
        resetDut();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t2_full_addr", {58'h0, bus.imem_addr}, 64'h2);
        checkOutput("t2_full_count", {48'h0, bus.fetch_count}, 64'h2);
        checkOutput("t2_full_head", bus.instr_pc, 64'h0);
        checkOutput("t2_full_valid", {63'h0, bus.instr_valid}, 64'h1);
        pushExp(32'hf800_0000, 64'h0);
        pushExp(32'hf800_8001, 64'h4);
        pushExp(32'h1000_0002, 64'h8);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("t2_head4", bus.instr_pc, 64'h4);
        tick();
        checkOutput("t2_head8", bus.instr_pc, 64'h8);
        checkOutput("t2_count4", {48'h0, bus.fetch_count}, 64'h4);

        // Redirect while head pc 8 is consumed in the same cycle
        applyStimulus(1'b0, 1'b1, 64'h2C, 1'b1);
        tick();
        checkOutput("t3_flush_valid", {63'h0, bus.instr_valid}, 64'h0);
        checkOutput("t3_redir_addr", {58'h0, bus.imem_addr}, 64'hB);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("t3_valid", {63'h0, bus.instr_valid}, 64'h1);
        checkOutput("t3_head_pc", bus.instr_pc, 64'h2C);
        checkOutput("t3_head_instr", {32'h0, bus.instr}, 64'h1000_000B);
        tick();

        // Misaligned redirect faults, illegal redirect updates, legal one recovers
        applyStimulus(1'b0, 1'b1, 64'h2E, 1'b0);
        tick();
        checkOutput("t4_fault", {63'h0, bus.fault}, 64'h1);
        checkOutput("t4_fault_pc", bus.fault_pc, 64'h2E);
        checkOutput("t4_valid", {63'h0, bus.instr_valid}, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("t4_fault_hold", {63'h0, bus.fault}, 64'h1);
        checkOutput("t4_no_fetch", {48'h0, bus.fetch_count}, 64'h6);
        applyStimulus(1'b0, 1'b1, 64'h104, 1'b0);
        tick();
        checkOutput("t4_fault_pc2", bus.fault_pc, 64'h104);
        checkOutput("t4_fault_still", {63'h0, bus.fault}, 64'h1);
        applyStimulus(1'b0, 1'b1, 64'h0, 1'b0);
        tick();
        checkOutput("t4_recover_fault", {63'h0, bus.fault}, 64'h0);
        checkOutput("t4_recover_addr", {58'h0, bus.imem_addr}, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("t4_resume_pc", bus.instr_pc, 64'h0);
        checkOutput("t4_resume_instr", {32'h0, bus.instr}, 64'hf800_0000);

        // Sequential fetch off the top of the ROM faults at 0x100
        resetDut();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 64'hF8, 1'b0);
        tick();
        pushExp(32'h1000_003E, 64'hF8);
        pushExp(32'h1000_003F, 64'hFC);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        checkOutput("t5_addr_fc", {58'h0, bus.imem_addr}, 64'h3F);
        tick();
        checkOutput("t5_addr_100", {58'h0, bus.imem_addr}, 64'h0);
        tick();
        checkOutput("t5_fault", {63'h0, bus.fault}, 64'h1);
        checkOutput("t5_fault_pc", bus.fault_pc, 64'h100);
        checkOutput("t5_valid", {63'h0, bus.instr_valid}, 64'h0);
        checkOutput("t5_count", {48'h0, bus.fetch_count}, 64'h2);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);

        // Reset mid-run with a full queue and a redirect pending
        resetDut();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t6_pre_count", {48'h0, bus.fetch_count}, 64'h2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 64'h40, 1'b0);
        tick();
        checkOutput("t6_valid", {63'h0, bus.instr_valid}, 64'h0);
        checkOutput("t6_count", {48'h0, bus.fetch_count}, 64'h0);
        checkOutput("t6_fault", {63'h0, bus.fault}, 64'h0);
        checkOutput("t6_addr", {58'h0, bus.imem_addr}, 64'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();
        checkOutput("t6_idle_valid", {63'h0, bus.instr_valid}, 64'h0);
        checkOutput("t6_idle_count", {48'h0, bus.fetch_count}, 64'h0);

        // Redirect in IDLE is ignored
        applyStimulus(1'b0, 1'b1, 64'h2C, 1'b1);
        tick();
        checkOutput("t6_idle_redir_addr", {58'h0, bus.imem_addr}, 64'h0);
        checkOutput("t6_idle_redir_fault", {63'h0, bus.fault}, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        tick();

        checkOutput("sb_drained", 64'(expQ.size()), 64'h0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
